// File: rtl/regfile_mp.sv
// Multi-port integer register file with fixed-priority writes, optional
// write-to-read bypass, hardwired-zero x0 and a one-bit-per-register busy scoreboard.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    input  logic                flush
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NWR-1:0]  wr_ok_s;
    logic            issue_ok_s;

    // Qualify write and issue requests; x0 targets are dropped when hardwired.
    always_comb begin
        wr_ok_s = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_ok_s[j] = wr_en[j] &&
                         !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == {AW{1'b0}}));
        end
        issue_ok_s = issue_en && !((ZERO_REG != 0) && (issue_rd == {AW{1'b0}}));
    end

    // Next state: later write ports overwrite earlier ones; clears precede the issue set.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
        end
        busy_d = flush ? {NREG{1'b0}} : busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_ok_s[j]) begin
                regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
        end
        if (issue_ok_s) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= {XLEN{1'b0}};
            end
            busy_q <= {NREG{1'b0}};
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    // Combinational read ports; reset forces zero even if a bypassed write is pending.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rs_data[i*XLEN +: XLEN] = regs_q[rs_addr[i*AW +: AW]];
            rs_busy[i]              = busy_q[rs_addr[i*AW +: AW]];
            for (int j = 0; j < NWR; j++) begin
                if ((BYPASS != 0) && wr_en[j] &&
                    (wr_addr[j*AW +: AW] == rs_addr[i*AW +: AW])) begin
                    rs_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                    rs_busy[i]              = 1'b0;
                end else begin
                    rs_busy[i] = rs_busy[i];
                end
            end
            if (!rst_n || ((ZERO_REG != 0) && (rs_addr[i*AW +: AW] == {AW{1'b0}}))) begin
                rs_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
                rs_busy[i]              = 1'b0;
            end else begin
                rs_busy[i] = rs_busy[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share the same stimulus; expected values are hand-computed constants.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic             clk;
    logic             rst_n;
    logic [2*AW-1:0]  rs_addr;
    logic [2*XLEN-1:0] rs_data_b, rs_data_n;
    logic [1:0]       rs_busy_b, rs_busy_n;
    logic [1:0]       wr_en;
    logic [2*AW-1:0]  wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic             issue_en;
    logic [AW-1:0]    issue_rd;
    logic             flush;

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data_b),
        .rs_busy(rs_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush)
    );

    regfile_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data_n),
        .rs_busy(rs_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr_en    = 2'b00;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        wr_en[p]              = 1'b1;
        wr_addr[p*AW +: AW]   = a;
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rs_addr[p*AW +: AW] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rs_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        issue_rd = '0;
        idle();
        // Writes and issue presented during reset must be ignored.
        set_wr(0, 5'd5, 32'h0000_1234);
        issue_en = 1'b1;
        issue_rd = 5'd5;
        set_rd(0, 5'd5);
        set_rd(1, 5'd0);
        #1;
        check("rst_data_b", rs_data_b[31:0], 32'h0);
        check("rst_busy_b", {31'd0, rs_busy_b[0]}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        check("rst_data_n", rs_data_n[31:0], 32'h0);
        rst_n = 1'b1;
        idle();
        #1;
        check("rst_no_write", rs_data_b[31:0], 32'h0);
        check("rst_no_busy", {31'd0, rs_busy_b[0]}, 32'h0);

        set_wr(0, 5'd1, 32'hAABB_CCDD);
        step();
        set_rd(0, 5'd1);
        #1;
        check("wr1_p0", rs_data_n[31:0], 32'hAABB_CCDD);
        check("wr1_p1_x0", rs_data_n[63:32], 32'h0);

        // x0 protection with bypass and issue attempt.
        set_wr(0, 5'd0, 32'hFFFF_FFFF);
        set_wr(1, 5'd0, 32'hFFFF_FFFF);
        issue_en = 1'b1;
        issue_rd = 5'd0;
        set_rd(0, 5'd0);
        #1;
        check("x0_bypass", rs_data_b[31:0], 32'h0);
        step();
        check("x0_data_b", rs_data_b[31:0], 32'h0);
        check("x0_data_n", rs_data_n[31:0], 32'h0);
        check("x0_busy", {30'd0, rs_busy_n}, 32'h0);

        // Port priority.
        set_wr(0, 5'd10, 32'h5555_5555);
        set_wr(1, 5'd10, 32'hAAAA_AAAA);
        set_rd(0, 5'd10);
        #1;
        check("prio_bypass", rs_data_b[31:0], 32'hAAAA_AAAA);
        step();
        check("prio_stored", rs_data_n[31:0], 32'hAAAA_AAAA);
        set_wr(0, 5'd20, 32'h2020_2020);
        set_wr(1, 5'd21, 32'h2121_2121);
        step();
        set_rd(0, 5'd20);
        set_rd(1, 5'd21);
        #1;
        check("dual_wr20", rs_data_n[31:0], 32'h2020_2020);
        check("dual_wr21", rs_data_n[63:32], 32'h2121_2121);

        // Bypass versus stored read, with busy forwarding.
        set_wr(0, 5'd7, 32'h1111_1111);
        issue_en = 1'b1;
        issue_rd = 5'd7;
        step();
        set_rd(0, 5'd7);
        #1;
        check("byp_old_n", rs_data_n[31:0], 32'h1111_1111);
        check("byp_busy_pre", {31'd0, rs_busy_n[0]}, 32'h1);
        set_wr(0, 5'd7, 32'hDEAD_BEEF);
        #1;
        check("byp_data_b", rs_data_b[31:0], 32'hDEAD_BEEF);
        check("byp_busy_b", {31'd0, rs_busy_b[0]}, 32'h0);
        check("byp_data_n", rs_data_n[31:0], 32'h1111_1111);
        check("byp_busy_n", {31'd0, rs_busy_n[0]}, 32'h1);
        step();
        check("byp_next_n", rs_data_n[31:0], 32'hDEAD_BEEF);
        check("byp_clr_n", {31'd0, rs_busy_n[0]}, 32'h0);

        // Scoreboard on register 3.
        set_rd(1, 5'd3);
        issue_en = 1'b1;
        issue_rd = 5'd3;
        #1;
        check("sb_pre", {31'd0, rs_busy_n[1]}, 32'h0);
        step();
        check("sb_set", {31'd0, rs_busy_n[1]}, 32'h1);
        set_wr(1, 5'd3, 32'h0000_0003);
        step();
        check("sb_clr", {31'd0, rs_busy_n[1]}, 32'h0);
        set_wr(0, 5'd3, 32'h0000_0033);
        issue_en = 1'b1;
        issue_rd = 5'd3;
        step();
        check("sb_issue_wins", {31'd0, rs_busy_n[1]}, 32'h1);
        issue_en = 1'b1;
        issue_rd = 5'd3;
        step();
        check("sb_reissue", {31'd0, rs_busy_b[1]}, 32'h1);
        set_wr(0, 5'd3, 32'h0000_0333);
        step();
        check("sb_first_wb", {31'd0, rs_busy_n[1]}, 32'h0);

        // Flush interplay on register 4.
        set_rd(1, 5'd4);
        issue_en = 1'b1;
        issue_rd = 5'd4;
        step();
        check("fl_set", {31'd0, rs_busy_n[1]}, 32'h1);
        flush = 1'b1;
        step();
        check("fl_clear", {31'd0, rs_busy_n[1]}, 32'h0);
        flush    = 1'b1;
        issue_en = 1'b1;
        issue_rd = 5'd4;
        step();
        check("fl_issue_wins", {31'd0, rs_busy_n[1]}, 32'h1);

        // Asynchronous reset mid-cycle.
        set_wr(0, 5'd2, 32'h2222_2222);
        issue_en = 1'b1;
        issue_rd = 5'd3;
        step();
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        #1;
        check("ar_pre_r1", rs_data_n[31:0], 32'hAABB_CCDD);
        check("ar_pre_r2", rs_data_n[63:32], 32'h2222_2222);
        set_rd(1, 5'd3);
        #1;
        check("ar_pre_busy3", {31'd0, rs_busy_n[1]}, 32'h1);
        set_rd(1, 5'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_r1_b", rs_data_b[31:0], 32'h0);
        check("ar_r2_n", rs_data_n[63:32], 32'h0);
        set_rd(1, 5'd3);
        #1;
        check("ar_busy3", {30'd0, rs_busy_n}, 32'h0);
        rst_n = 1'b1;
        #1;
        set_rd(1, 5'd2);
        #1;
        check("ar_after_r1", rs_data_n[31:0], 32'h0);
        check("ar_after_r2", rs_data_b[63:32], 32'h0);
        set_rd(1, 5'd3);
        #1;
        check("ar_after_busy3", {31'd0, rs_busy_b[1]}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, successor to the single-write/dual-read register file. Provides NRD combinational read ports, NWR write ports with fixed priority, optional write-to-read bypass, a hardwired-zero x0, and a per-register busy scoreboard that the issue stage sets and writeback clears. It sits between decode/issue (reads, issue marks) and writeback (writes).

## Interface
- XLEN, 32: register width in bits.
- NREG, 32: number of registers (power of 2, ≥2); AW = log2(NREG).
- NRD, 2: number of read ports.
- NWR, 2: number of write ports.
- BYPASS, 1: 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, and is never busy.

- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW].
- rs_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rs_busy  out  NRD  scoreboard busy bit for each read address.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- issue_en  in  1  mark issue_rd busy (instruction with destination issued).
- issue_rd  in  AW  destination being issued.
- flush  in  1  clear all busy bits (pipeline flush).

## Operation
- Storage: NREG x XLEN flops, plus an NREG-bit busy vector.
- Write: for each register r, the highest-index port j with wr_en[j] and wr_addr[j]==r writes wr_data[j] at the clock edge. Lower-index ports addressing the same register are discarded.
- Busy update at the clock edge, applied in this order:
  1. Clear: any enabled write to r clears busy[r]. flush clears every bit.
  2. Set: issue_en sets busy[issue_rd].
- Because set follows clear, issue beats both a same-cycle write and flush to the same register. The result is busy=1.
- ZERO_REG=1: writes with address 0 are dropped. issue_rd==0 does not set busy. rs_data for address 0 = 0 and rs_busy = 0, regardless of bypass.
- Read data, combinational per port:
  - BYPASS=1 and some wr_en[j] with wr_addr[j]==rs_addr[i]: return wr_data of the highest such j.
  - Otherwise: return the stored value.
- rs_busy[i] = busy[rs_addr[i]]. When BYPASS=1, it is forced to 0 if a same-cycle write hits that address.
- Scoreboard is one bit per register with no counting. A second issue to an already-busy register leaves it busy, and the first writeback clears it.

## Timing
- Reset (async assert, release on rst_n=1): all registers = 0 and all busy = 0. As a result, every rs_data = 0 and every rs_busy = 0 while in reset and right after it.
- Reset asserted in the same cycle as writes or issue: reset wins and no update is applied.
- Read latency is 0 cycles (combinational from rs_addr, wr_*, and state).
- Write latency is 1 edge:
  - BYPASS=1: visible in the same cycle.
  - BYPASS=0: visible in the cycle after the edge.
- Busy set or clear is visible on rs_busy in the cycle after the edge, except for the bypass clear, which is same-cycle.
- No handshakes and no stalls: every port is accepted every cycle.

## Test plan
- Reset and basic write: with rst_n=0, drive wr_en[0]=1, addr 5, data 0x1234 -> rs_data stays 0. After release, write addr 1 = 0xAABBCCDD -> rs_addr[0]=1 reads 0xAABBCCDD next cycle; port 1 at addr 0 reads 0.
- x0 protection: write addr 0 = 0xFFFFFFFF on both ports with issue_en=1, issue_rd=0 -> addr 0 reads 0 and rs_busy = 0.
- Port priority: same cycle, port0 writes addr 10 = 0x55555555 and port1 writes addr 10 = 0xAAAAAAAA -> addr 10 holds 0xAAAAAAAA. A separate cycle writing addr 20 on port0 and addr 21 on port1 -> both are stored.
- Bypass: with BYPASS=1, read addr 7 while writing 7 = 0xDEADBEEF -> same-cycle rs_data = 0xDEADBEEF and rs_busy = 0. With BYPASS=0 the same stimulus -> old value that cycle, 0xDEADBEEF next cycle.
- Scoreboard:
  - Issue rd 3 -> rs_busy=1 next cycle.
  - Writeback to 3 -> busy=0 next cycle.
  - Issue 3 and write 3 in the same cycle -> busy stays 1.
  - Issue 4, then flush -> busy clears; flush together with issue of 4 -> busy=1.
- Async reset mid-operation: with registers 1 and 2 and busy 3 set, pulse rst_n low between clock edges -> outputs go to 0 immediately, with no clock needed; reads of 1 and 2 return 0.
